motoro3_line_step_sequencer: RTL and testbench
==============================================

Name: motoro3_line_step_sequencer

Overview:
- Sequences the 3-phase line-commutation datapath.
- Drives the step index into the line-parameter calculation, latches the returned PWM-on length and sine-step length, and generates PWM periods for the step.
- Advances the step index with wrap-around in either direction.
- Sits between the motor control registers (start/stop/direction/pwmLen) and the phase drivers.

Parameters:
- STEP_MAX, 11, highest step index; steps run 0..STEP_MAX.
- LEN_W, 16, width of the plLen/slLen inputs and the period counter.

Ports:
- clk  input  1  system clock, rising edge.
- nRst  input  1  asynchronous active-low reset.
- iStart  input  1  level/pulse request to run, sampled in IDLE.
- iStop  input  1  request to stop; takes effect at end of the current PWM period.
- iDir  input  1  step direction: 1 counts up, 0 counts down; sampled on entry to LOAD.
- iPwmLen  input  8  PWM period in clocks; latched on start.
- iPlLen  input  LEN_W  PWM-on clocks for the current step, from the calc block.
- iSlLen  input  LEN_W  PWM periods per step for the current step, from the calc block.
- oLcStep  output  4  step index driven to the calc block.
- oPwm  output  1  PWM gate for the current step.
- oStepStb  output  1  one-cycle pulse on the last clock of each step.
- oBusy  output  1  high in every state except IDLE.
- oErr  output  1  sticky error: start requested with iPwmLen==0; cleared by the next accepted start.

Behaviour:
- Reset, asynchronous on nRst low:
  - State IDLE.
  - oLcStep=0, oPwm=0, oStepStb=0, oBusy=0, oErr=0.
  - All counters and latches 0.
- States: IDLE, LOAD, RUN.
- IDLE:
  - iStart=1 and iStop=0 and iPwmLen!=0: latch pwmLenR=iPwmLen, clear oErr, go to LOAD.
  - iStart=1 and iPwmLen==0: set oErr, stay in IDLE.
  - iStart and iStop in the same cycle: stop wins, stay in IDLE.
  - oLcStep holds its last value (resume point).
- LOAD, exactly 1 cycle; the combinational calc settles on oLcStep:
  - plR = min(iPlLen, pwmLenR).
  - slR = (iSlLen==0) ? 1 : iSlLen.
  - pwmCnt=0, perCnt=0; dirR=iDir.
  - oPwm=0. Next state RUN.
- RUN:
  - pwmCnt counts 0..pwmLenR-1.
  - oPwm = (pwmCnt < plR), registered; first RUN cycle has pwmCnt=0.
  - At pwmCnt==pwmLenR-1 with perCnt<slR-1: perCnt+1, pwmCnt=0.
  - At pwmCnt==pwmLenR-1 with perCnt==slR-1 (step end):
    - oStepStb=1 for this cycle.
    - oLcStep advances: up wraps STEP_MAX->0, down wraps 0->STEP_MAX.
    - Next state LOAD.
  - Stop request: iStop seen at any RUN cycle is held in stopPend. At the next pwmCnt==pwmLenR-1 go to IDLE, oPwm=0, with no step advance and no strobe. If that boundary is also a step end, stop wins: no advance, no strobe.
- Step timing: a step lasts exactly 1 + pwmLenR*slR clocks (LOAD plus RUN).
- plR==0 gives oPwm constantly 0. plR==pwmLenR gives oPwm constantly 1 in RUN.
- Widths:
  - Comparisons are unsigned.
  - pwmCnt is 8 bits; perCnt is LEN_W bits.
  - The clamp compares iPlLen zero-extended against pwmLenR.
- iPwmLen changes while running are ignored until the next start.

Decomposition:
- Shared package/include holds:
  - State encodings: IDLE=2'd0, LOAD=2'd1, RUN=2'd2.
  - STEP_MAX default.
  - LEN_W default.
- One natural sub-module: motoro3_pwm_period_gen. It holds pwmCnt, the compare against plR, and the period-end flag. The sequencer FSM and the step/period counters stay in the top.
- The top also instantiates the existing line-parameter calc block, with oLcStep feeding its lcStep and plLen/slLen feeding iPlLen/iSlLen. Bench may replace that block with a stub.

Test Plan:
- Up sequence:
  - Stimulus: pwmLen=4, stub plLen=1, slLen=2, iDir=1, start from reset.
  - Required: oPwm pattern 1000 1000 per step; oStepStb every 9 clocks; oLcStep 0,1,...,11,0.
- Down wrap:
  - Stimulus: iDir=0, start at step 0, pwmLen=2, slLen=1.
  - Required: oLcStep goes 0->11->10; each step lasts 3 clocks.
- Clamps:
  - Stimulus: plLen=200 with pwmLen=8, then slLen=0.
  - Required: oPwm high for all RUN cycles; step lasts 9 clocks (slR=1).
- Stop mid-period:
  - Stimulus: assert iStop at pwmCnt=1 of a pwmLen=6 period.
  - Required: IDLE after pwmCnt=5; no oStepStb; oLcStep unchanged.
  - Follow-up stimulus: restart.
  - Required: resumes at the same step.
- Error and simultaneous requests:
  - Stimulus: start with iPwmLen=0.
  - Required: oErr=1, oBusy=0.
  - Stimulus: iStart with iStop in the same cycle.
  - Required: stays in IDLE.
  - Stimulus: valid start.
  - Required: oErr clears.
- Async reset:
  - Stimulus: drop nRst mid-RUN at oLcStep=5.
  - Required: all outputs 0 immediately, without waiting for a clock edge; restart from step 0.

Source files
------------

// File: rtl/motoro3_line_step_sequencer_pkg.sv
// Shared types and defaults for the line-commutation step sequencer.
// Holds the FSM encoding, parameter defaults and the step wrap helper.
package motoro3_line_step_sequencer_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_LOAD = 2'd1,
        ST_RUN  = 2'd2
    } seq_state_t;

    localparam int STEP_MAX_DEF = 11;
    localparam int LEN_W_DEF    = 16;

    // Step index advance with wrap in either direction.
    function automatic logic [3:0] step_next(input logic [3:0] step,
                                             input logic       up,
                                             input logic [3:0] step_max);
        if (up)
            return (step >= step_max) ? 4'd0 : step + 4'd1;
        else
            return (step == 4'd0) ? step_max : step - 4'd1;
    endfunction

endpackage

// File: rtl/motoro3_pwm_period_gen.sv
// PWM period generator: period counter, on-length compare and period-end flag.
// The on-length is captured on load; the gate is registered one cycle ahead of the count.
module motoro3_pwm_period_gen (
    input  logic       clk,
    input  logic       nRst,
    input  logic       load,
    input  logic       adv,
    input  logic [7:0] pwm_len,
    input  logic [7:0] pl_in,
    output logic       pwm,
    output logic       period_end
);

    logic [7:0] cnt;
    logic [7:0] cnt_nxt;
    logic [7:0] pl_r;

    assign period_end = (cnt == pwm_len - 8'd1);
    assign cnt_nxt    = period_end ? 8'd0 : cnt + 8'd1;

    // pwm reflects the count value the counter will hold in the following cycle
    always_ff @(posedge clk or negedge nRst) begin
        if (!nRst) begin
            cnt  <= 8'd0;
            pl_r <= 8'd0;
            pwm  <= 1'b0;
        end else if (load) begin
            cnt  <= 8'd0;
            pl_r <= pl_in;
            pwm  <= (pl_in != 8'd0);
        end else if (adv) begin
            cnt  <= cnt_nxt;
            pwm  <= (cnt_nxt < pl_r);
        end else begin
            cnt  <= 8'd0;
            pwm  <= 1'b0;
        end
    end

endmodule

// File: rtl/motoro3_line_step_sequencer.sv
// Line-commutation step sequencer: drives the step index to the line-parameter calc,
// latches its PWM-on/sine-step lengths and generates PWM periods for each step.
//
// state   | meaning
// IDLE    | stopped; oLcStep holds the resume point
// LOAD    | one cycle; calc settles on oLcStep, lengths are latched
// RUN     | PWM periods for the current step; stop honoured at period end
module motoro3_line_step_sequencer
    import motoro3_line_step_sequencer_pkg::*;
#(
    parameter int STEP_MAX = STEP_MAX_DEF,
    parameter int LEN_W    = LEN_W_DEF
) (
    input  logic             clk,
    input  logic             nRst,
    input  logic             iStart,
    input  logic             iStop,
    input  logic             iDir,
    input  logic [7:0]       iPwmLen,
    input  logic [LEN_W-1:0] iPlLen,
    input  logic [LEN_W-1:0] iSlLen,
    output logic [3:0]       oLcStep,
    output logic             oPwm,
    output logic             oStepStb,
    output logic             oBusy,
    output logic             oErr
);

    localparam logic [3:0] STEP_MAX_L = 4'(STEP_MAX);

    seq_state_t       state, state_nxt;
    logic [7:0]       pwm_len_r;
    logic [7:0]       pl_clamp;
    logic [LEN_W-1:0] sl_r;
    logic [LEN_W-1:0] per_cnt;
    logic             dir_r;
    logic             stop_pend;
    logic             period_end;
    logic             last_per;
    logic             stop_now;
    logic             start_ok;
    logic             err_set;
    logic             step_end;
    logic             stop_end;
    logic             gen_adv;

    assign pl_clamp = (iPlLen < LEN_W'(pwm_len_r)) ? iPlLen[7:0] : pwm_len_r;
    assign last_per = (per_cnt == sl_r - LEN_W'(1));
    assign stop_now = stop_pend | iStop;
    assign gen_adv  = (state == ST_RUN) && (state_nxt == ST_RUN);

    motoro3_pwm_period_gen u_pwm (
        .clk        (clk),
        .nRst       (nRst),
        .load       (state == ST_LOAD),
        .adv        (gen_adv),
        .pwm_len    (pwm_len_r),
        .pl_in      (pl_clamp),
        .pwm        (oPwm),
        .period_end (period_end)
    );

    always_ff @(posedge clk or negedge nRst) begin
        if (!nRst) state <= ST_IDLE;
        else       state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        start_ok  = 1'b0;
        err_set   = 1'b0;
        step_end  = 1'b0;
        stop_end  = 1'b0;
        case (state)
            ST_IDLE: begin
                if (iStart) begin
                    if (iPwmLen == 8'd0) begin
                        err_set = 1'b1;
                    end else if (!iStop) begin
                        start_ok  = 1'b1;
                        state_nxt = ST_LOAD;
                    end
                end
            end
            ST_LOAD: state_nxt = ST_RUN;
            ST_RUN: begin
                // a pending stop at a period boundary overrides the step advance
                if (period_end) begin
                    if (stop_now) begin
                        stop_end  = 1'b1;
                        state_nxt = ST_IDLE;
                    end else if (last_per) begin
                        step_end  = 1'b1;
                        state_nxt = ST_LOAD;
                    end
                end
            end
            default: state_nxt = ST_IDLE;
        endcase
    end

    assign oStepStb = step_end;
    assign oBusy    = (state != ST_IDLE);

    always_ff @(posedge clk or negedge nRst) begin
        if (!nRst) begin
            pwm_len_r <= 8'd0;
            sl_r      <= '0;
            per_cnt   <= '0;
            dir_r     <= 1'b0;
            stop_pend <= 1'b0;
            oLcStep   <= 4'd0;
            oErr      <= 1'b0;
        end else begin
            if (start_ok) begin
                pwm_len_r <= iPwmLen;
                oErr      <= 1'b0;
            end else if (err_set) begin
                oErr      <= 1'b1;
            end
            if (state == ST_LOAD) begin
                sl_r    <= (iSlLen == '0) ? LEN_W'(1) : iSlLen;
                per_cnt <= '0;
                dir_r   <= iDir;
            end else if (state == ST_RUN && period_end && !stop_now && !last_per) begin
                per_cnt <= per_cnt + LEN_W'(1);
            end
            if (stop_end)
                stop_pend <= 1'b0;
            else if (state == ST_RUN)
                stop_pend <= stop_now;
            if (step_end)
                oLcStep <= step_next(oLcStep, dir_r, STEP_MAX_L);
        end
    end

endmodule

// File: tb/tb_motoro3_line_step_sequencer.sv
// Bench for the line step sequencer: IDLE request table, directed step/stop/reset
// sequences and randomized runs against a trace-building reference model.
module tb_motoro3_line_step_sequencer;

    logic        clk = 1'b0;
    logic        nRst;
    logic        iStart, iStop, iDir;
    logic [7:0]  iPwmLen;
    logic [15:0] iPlLen, iSlLen;
    logic [3:0]  oLcStep;
    logic        oPwm, oStepStb, oBusy, oErr;

    // stand-in for the line-parameter calc: per-step lookup on oLcStep
    logic [15:0] pl_tab [16];
    logic [15:0] sl_tab [16];
    assign iPlLen = pl_tab[oLcStep];
    assign iSlLen = sl_tab[oLcStep];

    int checks = 0;
    int errors = 0;
    int model_step = 0;

    typedef struct {
        bit pwm;
        bit stb;
        int step;
        bit pe;
        bit ld;
    } cyc_t;

    typedef struct {
        bit         start;
        bit         stop;
        logic [7:0] len;
        bit         busy;
        bit         err;
    } vec_t;

    motoro3_line_step_sequencer dut (
        .clk      (clk),
        .nRst     (nRst),
        .iStart   (iStart),
        .iStop    (iStop),
        .iDir     (iDir),
        .iPwmLen  (iPwmLen),
        .iPlLen   (iPlLen),
        .iSlLen   (iSlLen),
        .oLcStep  (oLcStep),
        .oPwm     (oPwm),
        .oStepStb (oStepStb),
        .oBusy    (oBusy),
        .oErr     (oErr)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic set_tables(input int pl, input int sl);
        for (int i = 0; i < 16; i++) begin
            pl_tab[i] = 16'(pl);
            sl_tab[i] = 16'(sl);
        end
    endtask

    function automatic int nxt(input int s, input bit up);
        return up ? (s + 1) % 12 : (s + 11) % 12;
    endfunction

    // Builds the expected per-cycle trace of nsteps steps from model_step, runs the DUT,
    // pulses iStop for one cycle at trace index ts_in and expects IDLE after the next period end.
    task automatic run_seq(input int L, input bit up, input int nsteps, input int ts_in);
        cyc_t tr[$];
        cyc_t c;
        int s, pl, sl, ts, e;
        s = model_step;
        for (int k = 0; k < nsteps; k++) begin
            pl = (int'(pl_tab[s]) < L) ? int'(pl_tab[s]) : L;
            sl = (sl_tab[s] == 16'd0) ? 1 : int'(sl_tab[s]);
            c.pwm = 0; c.stb = 0; c.step = s; c.pe = 0; c.ld = 1;
            tr.push_back(c);
            for (int p = 0; p < sl; p++)
                for (int q = 0; q < L; q++) begin
                    c.pwm = (q < pl);
                    c.stb = (p == sl - 1) && (q == L - 1);
                    c.pe  = (q == L - 1);
                    c.ld  = 0;
                    tr.push_back(c);
                end
            s = nxt(s, up);
        end
        if (ts_in < 0)               ts = $urandom_range(1, tr.size() - 1);
        else if (ts_in >= tr.size()) ts = tr.size() - 1;
        else                         ts = ts_in;
        if (tr[ts].ld) ts++;
        e = ts;
        while (!tr[e].pe) e++;
        tr[e].stb = 0;

        iPwmLen = 8'(L); iDir = up; iStart = 1'b1; iStop = 1'b0;
        @(posedge clk); #1;
        iStart  = 1'b0;
        iPwmLen = 8'($urandom);
        for (int i = 0; i <= e; i++) begin
            iStop = (i == ts);
            @(negedge clk);
            check($sformatf("trace[%0d] {pwm,stb,busy,step}", i),
                  {oPwm, oStepStb, oBusy, oLcStep},
                  {tr[i].pwm, tr[i].stb, 1'b1, 4'(tr[i].step)});
            @(posedge clk); #1;
        end
        iStop = 1'b0;
        @(negedge clk);
        check("stop_idle {pwm,stb,busy,step}", {oPwm, oStepStb, oBusy, oLcStep},
              {3'b000, 4'(tr[e].step)});
        model_step = tr[e].step;
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        vec_t tbl [7];
        bit found;
        tbl[0] = '{start: 0, stop: 0, len: 8'd5, busy: 0, err: 0};
        tbl[1] = '{start: 1, stop: 0, len: 8'd0, busy: 0, err: 1};
        tbl[2] = '{start: 1, stop: 1, len: 8'd3, busy: 0, err: 1};
        tbl[3] = '{start: 0, stop: 0, len: 8'd7, busy: 0, err: 1};
        tbl[4] = '{start: 1, stop: 0, len: 8'd3, busy: 1, err: 0};
        tbl[5] = '{start: 1, stop: 1, len: 8'd0, busy: 0, err: 1};
        tbl[6] = '{start: 1, stop: 0, len: 8'd1, busy: 1, err: 0};

        set_tables(1, 1);
        nRst = 1'b0; iStart = 1'b0; iStop = 1'b0; iDir = 1'b1; iPwmLen = 8'd0;
        #12;
        check("reset {pwm,stb,busy,err}", {oPwm, oStepStb, oBusy, oErr}, 0);
        check("reset step", oLcStep, 0);
        @(posedge clk); #1;
        nRst = 1'b1;

        for (int i = 0; i < 7; i++) begin
            @(posedge clk); #1;
            iStart = tbl[i].start; iStop = tbl[i].stop; iPwmLen = tbl[i].len;
            @(posedge clk); #1;
            iStart = 1'b0; iStop = 1'b0;
            @(negedge clk);
            check($sformatf("vec%0d busy", i), oBusy, tbl[i].busy);
            check($sformatf("vec%0d err", i), oErr, tbl[i].err);
            if (tbl[i].busy) begin
                iStop = 1'b1;
                for (int n = 0; n < 40; n++) begin
                    @(negedge clk);
                    if (!oBusy) break;
                end
                check($sformatf("vec%0d stop to idle", i), oBusy, 0);
                check($sformatf("vec%0d step held", i), oLcStep, 0);
                @(posedge clk); #1;
                iStop = 1'b0;
            end
        end

        // up sequence through the wrap: 0..11,0 at 9 clocks per step
        set_tables(1, 2);
        run_seq(4, 1'b1, 13, 9999);
        // down wrap 0 -> 11 -> 10, 3 clocks per step
        set_tables(1, 1);
        run_seq(2, 1'b0, 3, 9999);
        // on-length clamped to the period, zero sine-step length treated as one
        set_tables(200, 0);
        run_seq(8, 1'b1, 2, 9999);
        // stop at pwmCnt=1 of a 6-clock period, then resume at the same step
        set_tables(2, 3);
        run_seq(6, 1'b1, 2, 2);
        run_seq(6, 1'b1, 1, 9999);

        // async reset mid-RUN at step 5
        set_tables(2, 1);
        @(posedge clk); #1;
        iPwmLen = 8'd2; iDir = 1'b1; iStart = 1'b1;
        @(posedge clk); #1;
        iStart = 1'b0;
        found = 0;
        for (int n = 0; n < 200; n++) begin
            @(negedge clk);
            if (oLcStep == 4'd5 && oPwm) begin
                found = 1;
                break;
            end
        end
        check("reach step 5 in RUN", found, 1);
        @(posedge clk); #3;
        nRst = 1'b0;
        #1;
        check("async reset {pwm,stb,busy,err}", {oPwm, oStepStb, oBusy, oErr}, 0);
        check("async reset step", oLcStep, 0);
        @(posedge clk); #1;
        nRst = 1'b1;
        model_step = 0;
        run_seq(2, 1'b1, 2, 9999);

        for (int it = 0; it < 25; it++) begin
            for (int i = 0; i < 16; i++) begin
                pl_tab[i] = 16'($urandom_range(0, 8));
                sl_tab[i] = 16'($urandom_range(0, 3));
            end
            repeat ($urandom_range(0, 3)) @(posedge clk);
            #1;
            run_seq($urandom_range(1, 6), 1'($urandom_range(0, 1)), $urandom_range(1, 5), -1);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
